// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter and registered output stage for the shared physical-register-file
// writeback / complete bus. One requester is granted per cycle; its beat appears one cycle later.
module wb_bus_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int PHYS_REG_WIDTH  = 6,
    parameter int WORD_WIDTH      = 32,
    parameter int ROB_INDEX_WIDTH = 5
) (
    input  logic                                  CLK,
    input  logic                                  nRST,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*PHYS_REG_WIDTH-1:0]     req_phys_reg_tag,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]         req_data,
    input  logic [NUM_REQ*ROB_INDEX_WIDTH-1:0]    req_ROB_index,
    input  logic                                  wb_ready,
    input  logic                                  flush,
    output logic                                  wb_valid,
    output logic [PHYS_REG_WIDTH-1:0]             wb_phys_reg_tag,
    output logic [WORD_WIDTH-1:0]                 wb_data,
    output logic [ROB_INDEX_WIDTH-1:0]            wb_ROB_index,
    output logic [$clog2(NUM_REQ)-1:0]            wb_source
);

    localparam int SRC_WIDTH = $clog2(NUM_REQ);

    logic [SRC_WIDTH-1:0]       r_rr_ptr;
    logic                       r_wb_valid;
    logic [PHYS_REG_WIDTH-1:0]  r_wb_tag;
    logic [WORD_WIDTH-1:0]      r_wb_data;
    logic [ROB_INDEX_WIDTH-1:0] r_wb_rob;
    logic [SRC_WIDTH-1:0]       r_wb_source;

    logic                       w_out_free;
    logic                       w_arb_en;
    logic                       w_grant_any;
    logic [SRC_WIDTH-1:0]       w_grant_idx;
    int                         w_best_dist;
    logic [PHYS_REG_WIDTH-1:0]  w_sel_tag;
    logic [WORD_WIDTH-1:0]      w_sel_data;
    logic [ROB_INDEX_WIDTH-1:0] w_sel_rob;
    logic [SRC_WIDTH-1:0]       w_next_ptr;

    // Distance of requester idx from the current priority holder, walking upward with wrap.
    // Plain compare-and-add keeps this correct when NUM_REQ is not a power of two.
    function automatic int rr_distance(input int idx, input int ptr);
        return (idx >= ptr) ? (idx - ptr) : (idx + NUM_REQ - ptr);
    endfunction

    assign w_out_free = !r_wb_valid || wb_ready;
    assign w_arb_en   = nRST && w_out_free && !flush;

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_best_dist = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_en && req_valid[i] && (rr_distance(i, int'(r_rr_ptr)) < w_best_dist)) begin
                w_grant_any = 1'b1;
                w_grant_idx = SRC_WIDTH'(i);
                w_best_dist = rr_distance(i, int'(r_rr_ptr));
            end
        end
    end

    // One-hot grant vector and payload mux for the winning requester.
    always_comb begin
        req_ready  = '0;
        w_sel_tag  = '0;
        w_sel_data = '0;
        w_sel_rob  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_any && (w_grant_idx == SRC_WIDTH'(i))) begin
                req_ready[i] = 1'b1;
                w_sel_tag    = req_phys_reg_tag[i*PHYS_REG_WIDTH +: PHYS_REG_WIDTH];
                w_sel_data   = req_data[i*WORD_WIDTH +: WORD_WIDTH];
                w_sel_rob    = req_ROB_index[i*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH];
            end
        end
    end

    assign w_next_ptr = (w_grant_idx == SRC_WIDTH'(NUM_REQ - 1)) ? '0
                                                                 : (w_grant_idx + SRC_WIDTH'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr_ptr <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr <= w_next_ptr;
        end
    end

    // Flush wins over a waiting beat; a stalled beat (valid & !wb_ready) holds everything.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wb_valid  <= 1'b0;
            r_wb_tag    <= '0;
            r_wb_data   <= '0;
            r_wb_rob    <= '0;
            r_wb_source <= '0;
        end else if (flush) begin
            r_wb_valid  <= 1'b0;
        end else if (w_grant_any) begin
            r_wb_valid  <= 1'b1;
            r_wb_tag    <= w_sel_tag;
            r_wb_data   <= w_sel_data;
            r_wb_rob    <= w_sel_rob;
            r_wb_source <= w_grant_idx;
        end else if (w_out_free) begin
            r_wb_valid  <= 1'b0;
        end
    end

    assign wb_valid        = r_wb_valid;
    assign wb_phys_reg_tag = r_wb_tag;
    assign wb_data         = r_wb_data;
    assign wb_ROB_index    = r_wb_rob;
    assign wb_source       = r_wb_source;

    a_ready_onehot0: assert property (@(posedge CLK) disable iff (!nRST) $onehot0(req_ready));

    a_valid_needs_grant: assert property (@(posedge CLK) disable iff (!nRST)
        $rose(r_wb_valid) |-> $past(w_grant_any));

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios plus randomized traffic
// compared against a queue-free behavioural model of the round-robin writeback bus.
module tb_wb_bus_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int SW = 2;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*TW-1:0] req_phys_reg_tag;
    logic [N*DW-1:0] req_data;
    logic [N*RW-1:0] req_ROB_index;
    logic            wb_ready;
    logic            flush;
    logic            wb_valid;
    logic [TW-1:0]   wb_phys_reg_tag;
    logic [DW-1:0]   wb_data;
    logic [RW-1:0]   wb_ROB_index;
    logic [SW-1:0]   wb_source;

    logic [TW-1:0] p_tag  [N];
    logic [DW-1:0] p_data [N];
    logic [RW-1:0] p_rob  [N];

    int            m_ptr;
    bit            m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    logic [RW-1:0] m_rob;
    int            m_src;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_phys_reg_tag[gi*TW +: TW] = p_tag[gi];
        assign req_data[gi*DW +: DW]         = p_data[gi];
        assign req_ROB_index[gi*RW +: RW]    = p_rob[gi];
    end

    wb_bus_arbiter #(
        .NUM_REQ(N), .PHYS_REG_WIDTH(TW), .WORD_WIDTH(DW), .ROB_INDEX_WIDTH(RW)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_phys_reg_tag(req_phys_reg_tag), .req_data(req_data), .req_ROB_index(req_ROB_index),
        .wb_ready(wb_ready), .flush(flush),
        .wb_valid(wb_valid), .wb_phys_reg_tag(wb_phys_reg_tag), .wb_data(wb_data),
        .wb_ROB_index(wb_ROB_index), .wb_source(wb_source)
    );

    // Reference: whoever is valid first, counting up from the priority pointer modulo N.
    function automatic int exp_grant();
        if (!nRST || flush || (m_valid && !wb_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = exp_grant();
        return (g >= 0) ? N'(1 << g) : '0;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_rob = '0; m_src = 0;
    endtask

    task automatic model_step();
        int g;
        g = exp_grant();
        if (flush) begin
            m_valid = 0;
        end else if (g >= 0) begin
            m_valid = 1;
            m_tag   = p_tag[g];
            m_data  = p_data[g];
            m_rob   = p_rob[g];
            m_src   = g;
            m_ptr   = (g + 1) % N;
        end else if (wb_ready || !m_valid) begin
            m_valid = 0;
        end
    endtask

    // Advance one clock: model consumes the inputs seen at the edge, then wait to the negedge.
    task automatic tick();
        model_step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 1'b0; req_valid = '0; wb_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_tag[i] = TW'(i + 1); p_data[i] = DW'(32'h1000 + i); p_rob[i] = RW'(i + 4);
        end
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [N-1:0] rdy;
        do_reset();
        n_tests++;
        if ({wb_valid, wb_phys_reg_tag, wb_data, wb_ROB_index, wb_source} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b tag=%0d data=%h rob=%0d src=%0d want all zero",
                     wb_valid, wb_phys_reg_tag, wb_data, wb_ROB_index, wb_source);
        end
        req_valid = 4'b0001;
        #1 tick();
        n_tests++;
        if (wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_prebeat wb_valid got %b want 1", wb_valid);
        end
        req_valid = 4'b1111;
        #2 nRST = 1'b0;
        #1 rdy = req_ready;
        n_tests++;
        if (wb_valid !== 1'b0 || rdy !== '0) begin
            n_fail++;
            $display("FAIL reset_async got wb_valid=%b req_ready=%b want 0 and 0000", wb_valid, rdy);
        end
        @(negedge CLK);
        nRST = 1'b1;
        model_reset();
        req_valid = 4'b0110;
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL reset_first_grant got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        n_tests++;
        if (wb_valid !== 1'b1 || wb_source !== 2'd1 || wb_data !== p_data[1]) begin
            n_fail++;
            $display("FAIL reset_first_beat got v=%b src=%0d data=%h want 1/1/%h",
                     wb_valid, wb_source, wb_data, p_data[1]);
        end
    endtask

    task automatic test_round_robin();
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        req_valid = 4'b1111;
        wb_ready  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_tests++;
            if (req_ready !== N'(1 << seq[c])) begin
                n_fail++; $display("FAIL rr_grant[%0d] got %b want one-hot %0d", c, req_ready, seq[c]);
            end
            tick();
            n_tests++;
            if (wb_valid !== 1'b1 || wb_source !== SW'(seq[c]) || wb_phys_reg_tag !== p_tag[seq[c]]) begin
                n_fail++;
                $display("FAIL rr_beat[%0d] got v=%b src=%0d tag=%0d want 1/%0d/%0d",
                         c, wb_valid, wb_source, wb_phys_reg_tag, seq[c], p_tag[seq[c]]);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        p_tag[2] = 6'd17; p_data[2] = 32'hDEADBEEF; p_rob[2] = 5'd9;
        req_valid = 4'b0100;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_grant got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        n_tests++;
        if (wb_valid !== 1'b1 || wb_phys_reg_tag !== 6'd17 || wb_data !== 32'hDEADBEEF ||
            wb_ROB_index !== 5'd9 || wb_source !== 2'd2) begin
            n_fail++;
            $display("FAIL single_beat got v=%b tag=%0d data=%h rob=%0d src=%0d want 1/17/deadbeef/9/2",
                     wb_valid, wb_phys_reg_tag, wb_data, wb_ROB_index, wb_source);
        end
        req_valid = 4'b1111;
        #1;
        n_tests++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL single_next_ptr got %b want 1000", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 4'b0100;
        #1 tick();
        req_valid = 4'b0011;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_grant0 got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL wrap_grant1 got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        n_tests++;
        if (wb_valid !== 1'b1 || wb_source !== 2'd1) begin
            n_fail++; $display("FAIL wrap_beat got v=%b src=%0d want 1/1", wb_valid, wb_source);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] e_tag;
        logic [DW-1:0] e_data;
        logic [RW-1:0] e_rob;
        do_reset();
        wb_ready  = 1'b0;
        p_tag[0]  = 6'd0; p_data[0] = 32'hCAFE0000; p_rob[0] = 5'd21;
        e_tag = p_tag[0]; e_data = p_data[0]; e_rob = p_rob[0];
        req_valid = 4'b0001;
        #1 tick();
        p_tag[0]  = 6'd33; p_data[0] = 32'h12345678; p_rob[0] = 5'd3;
        req_valid = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (req_ready !== '0) begin
                n_fail++; $display("FAIL bp_ready[%0d] got %b want 0000", c, req_ready);
            end
            tick();
            n_tests++;
            if ({wb_valid, wb_phys_reg_tag, wb_data, wb_ROB_index, wb_source} !==
                {1'b1, e_tag, e_data, e_rob, 2'd0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b tag=%0d data=%h rob=%0d src=%0d want 1/%0d/%h/%0d/0",
                         c, wb_valid, wb_phys_reg_tag, wb_data, wb_ROB_index, wb_source, e_tag, e_data, e_rob);
            end
        end
        wb_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_release_grant got %b want 0010", req_ready);
        end
        tick();
        req_valid = 4'b0001;
        n_tests++;
        if (wb_valid !== 1'b1 || wb_source !== 2'd1 || wb_data !== p_data[1]) begin
            n_fail++;
            $display("FAIL bp_release_beat got v=%b src=%0d data=%h want 1/1/%h",
                     wb_valid, wb_source, wb_data, p_data[1]);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 4'b0001;
        #1 tick();
        wb_ready  = 1'b0;
        req_valid = 4'b0011;
        flush     = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== '0) begin
            n_fail++; $display("FAIL flush_ready got %b want 0000", req_ready);
        end
        tick();
        flush = 1'b0;
        n_tests++;
        if (wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_drop got wb_valid=%b want 0", wb_valid);
        end
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL flush_ptr_hold got %b want 0010", req_ready);
        end
        tick();
        req_valid = 4'b0001;
        n_tests++;
        if (wb_valid !== 1'b1 || wb_source !== 2'd1) begin
            n_fail++; $display("FAIL flush_after_beat got v=%b src=%0d want 1/1", wb_valid, wb_source);
        end
        wb_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        int  g;
        bit  was_flush;
        do_reset();
        was_flush = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (was_flush && req_valid[i] && $urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    p_tag[i]  = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom);
                    p_data[i] = $urandom;
                    p_rob[i]  = RW'($urandom);
                end
            end
            flush    = ($urandom_range(0, 15) == 0);
            wb_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_tests++;
            if (req_ready !== exp_ready()) begin
                n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", c, req_ready, exp_ready());
            end
            g = exp_grant();
            was_flush = flush;
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
            n_tests++;
            if (wb_valid !== m_valid ||
                (m_valid && {wb_phys_reg_tag, wb_data, wb_ROB_index, wb_source} !==
                            {m_tag, m_data, m_rob, SW'(m_src)})) begin
                n_fail++;
                $display("FAIL rand_beat[%0d] got v=%b tag=%0d data=%h rob=%0d src=%0d want v=%b tag=%0d data=%h rob=%0d src=%0d",
                         c, wb_valid, wb_phys_reg_tag, wb_data, wb_ROB_index, wb_source,
                         m_valid, m_tag, m_data, m_rob, m_src);
            end
        end
        flush = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_wrap();
        test_backpressure();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
